// File: rtl/mors_to_num_pkg.sv
// Shared Morse definitions for the mors_to_num receiver.
// Contents:
//   - unit constants (dot/dash mark lengths, char/word gap lengths, in units)
//   - FSM state encoding (IDLE, MARK, SPACE, GAP)
//   - decoded-digit result type
//   - digit_pattern(): the 5-element pattern of digit 0-9, first element in bit 4, 1 = dash
package mors_to_num_pkg;

  localparam int DOT_UNITS       = 1;
  localparam int DASH_UNITS      = 3;
  localparam int CHAR_GAP_UNITS  = 3;
  localparam int WORD_GAP_UNITS  = 7;
  localparam int ELEMS_PER_DIGIT = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } digit_dec_t;

  function automatic logic [4:0] digit_pattern(input logic [3:0] d);
    logic [4:0] pat;
    case (d)
      4'd0:    pat = 5'b11111;
      4'd1:    pat = 5'b01111;
      4'd2:    pat = 5'b00111;
      4'd3:    pat = 5'b00011;
      4'd4:    pat = 5'b00001;
      4'd5:    pat = 5'b00000;
      4'd6:    pat = 5'b10000;
      4'd7:    pat = 5'b11000;
      4'd8:    pat = 5'b11100;
      4'd9:    pat = 5'b11110;
      default: pat = 5'b00000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/mors_to_num_digit_lut.sv
// Combinational Morse digit decoder.
// Ports:
//   elem      in  5  collected elements, first element in bit 4, 1 = dash
//   elem_cnt  in  3  number of elements collected
//   dec       out    {valid, digit}; valid only for exactly five elements forming a digit
module mors_to_num_digit_lut
  import mors_to_num_pkg::*;
(
  input  logic [4:0] elem,
  input  logic [2:0] elem_cnt,
  output digit_dec_t dec
);

  // Search the ten digit patterns for a match
  always_comb begin
    dec = '0;
    if (elem_cnt == 3'(ELEMS_PER_DIGIT)) begin
      for (int i = 0; i < 10; i++) begin
        if (elem == digit_pattern(4'(i))) begin
          dec.valid = 1'b1;
          dec.digit = 4'(i);
        end else begin
        end
      end
    end else begin
      dec = '0;
    end
  end

endmodule

// File: rtl/mors_to_num.sv
// Morse receiver: measures mark/space run lengths on `mors`, rebuilds dots and
// dashes, decodes digit characters and accumulates them into a 0..31 number.
// A word gap ends the number with either a num_valid or an err pulse.
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous active-low reset
//   mors       in   1  Morse line (1 = mark), synchronous to clk
//   num        out  5  last decoded number, held until the next num_valid
//   num_valid  out  1  one-cycle pulse, num updated in the same cycle
//   err        out  1  one-cycle pulse in place of num_valid for a malformed number
//   busy       out  1  high while a number is in progress
module mors_to_num
  import mors_to_num_pkg::*;
#(
  parameter int UNIT_CYC   = 1,
  parameter int CHAR_UNITS = CHAR_GAP_UNITS,
  parameter int WORD_UNITS = WORD_GAP_UNITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mors,
  output logic [4:0] num,
  output logic       num_valid,
  output logic       err,
  output logic       busy
);

  localparam int RUN_MAX = WORD_UNITS * UNIT_CYC;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(RUN_MAX);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] CHAR_RUN = RUN_W'(CHAR_UNITS * UNIT_CYC);
  // Marks shorter than the dot/dash midpoint (2 units) are dots
  localparam logic [RUN_W-1:0] DASH_MIN = RUN_W'(((DOT_UNITS + DASH_UNITS) / 2) * UNIT_CYC);

  logic             level_r;
  logic [RUN_W-1:0] run_cnt_r;
  logic [RUN_W-1:0] run_nxt_s;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             elem_end_s;
  logic             char_end_s;
  logic             word_end_s;
  logic             is_dash_s;
  logic [4:0]       elem_r;
  logic [2:0]       elem_cnt_r;
  logic [4:0]       acc_r;
  logic             err_flag_r;
  logic [8:0]       acc_mul_s;
  digit_dec_t       dec_s;
  logic [4:0]       num_r;
  logic             num_valid_r;
  logic             err_r;
  logic             busy_r;

  mors_to_num_digit_lut u_lut (
    .elem     (elem_r),
    .elem_cnt (elem_cnt_r),
    .dec      (dec_s)
  );

  // Run length including the current sample: restarts at 1 on a level change, saturates
  always_comb begin
    if (mors != level_r) begin
      run_nxt_s = RUN_ONE;
    end else if (run_cnt_r == RUN_SAT) begin
      run_nxt_s = RUN_SAT;
    end else begin
      run_nxt_s = run_cnt_r + RUN_ONE;
    end
  end

  // In MARK the registered run is the mark length seen so far
  assign is_dash_s = (run_cnt_r >= DASH_MIN);
  assign acc_mul_s = ({4'b0000, acc_r} * 9'd10) + {5'b00000, dec_s.digit};

  // Next-state logic and event strobes for element, character and word ends
  always_comb begin
    state_nxt_s = state_r;
    elem_end_s  = 1'b0;
    char_end_s  = 1'b0;
    word_end_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mors) begin
          state_nxt_s = ST_MARK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MARK: begin
        if (!mors) begin
          state_nxt_s = ST_SPACE;
          elem_end_s  = 1'b1;
        end else begin
          state_nxt_s = ST_MARK;
        end
      end
      ST_SPACE: begin
        if (mors) begin
          state_nxt_s = ST_MARK;
        end else if (run_nxt_s == CHAR_RUN) begin
          state_nxt_s = ST_GAP;
          char_end_s  = 1'b1;
        end else begin
          state_nxt_s = ST_SPACE;
        end
      end
      ST_GAP: begin
        if (mors) begin
          state_nxt_s = ST_MARK;
        end else if (run_nxt_s == RUN_SAT) begin
          state_nxt_s = ST_IDLE;
          word_end_s  = 1'b1;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Line level, run counter and FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_r   <= 1'b0;
      run_cnt_r <= '0;
      state_r   <= ST_IDLE;
    end else begin
      level_r   <= mors;
      run_cnt_r <= run_nxt_s;
      state_r   <= state_nxt_s;
    end
  end

  // Element shift register, digit accumulation and malformed-number flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      elem_r     <= 5'b00000;
      elem_cnt_r <= 3'd0;
      acc_r      <= 5'd0;
      err_flag_r <= 1'b0;
    end else if (elem_end_s) begin
      if (elem_cnt_r == 3'(ELEMS_PER_DIGIT)) begin
        // Too many elements: the character cannot be a digit
        err_flag_r <= 1'b1;
      end else begin
        elem_r     <= {elem_r[3:0], is_dash_s};
        elem_cnt_r <= elem_cnt_r + 3'd1;
      end
    end else if (char_end_s) begin
      elem_r     <= 5'b00000;
      elem_cnt_r <= 3'd0;
      if (err_flag_r) begin
        // Number already bad: later digits are ignored
        acc_r <= acc_r;
      end else if (!dec_s.valid) begin
        err_flag_r <= 1'b1;
      end else if (acc_mul_s > 9'd31) begin
        err_flag_r <= 1'b1;
        acc_r      <= 5'd31;
      end else begin
        acc_r <= acc_mul_s[4:0];
      end
    end else if (word_end_s) begin
      acc_r      <= 5'd0;
      err_flag_r <= 1'b0;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Registered outputs: result pulses on word end, busy follows the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_r       <= 5'd0;
      num_valid_r <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r      <= (state_nxt_s != ST_IDLE);
      num_valid_r <= word_end_s & ~err_flag_r;
      err_r       <= word_end_s & err_flag_r;
      if (word_end_s && !err_flag_r) begin
        num_r <= acc_r;
      end else begin
        num_r <= num_r;
      end
    end
  end

  assign num       = num_r;
  assign num_valid = num_valid_r;
  assign err       = err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mors_to_num.sv
// Self-checking bench for mors_to_num: one instance at 1 cycle/unit and one at
// 4 cycles/unit. Words are described as lists of dot/dash strings; the expected
// number is computed from a digit table with integer arithmetic.
module tb_mors_to_num;

  localparam byte DASH_CH = 8'h2D;  // '-'

  logic       clk = 1'b0;
  logic       rst;
  logic       m;
  logic       sel;
  logic       mors1, mors4;
  logic [4:0] num1, num4;
  logic       nv1, nv4, er1, er4, bs1, bs4;
  logic [4:0] o_num;
  logic       o_nv, o_er, o_bs;

  int    n_vec = 0;
  int    n_bad = 0;
  int    u;
  int    exp_num [2];
  string pat [10];
  string word_q [$];

  always #5 clk = ~clk;

  mors_to_num #(.UNIT_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .mors(mors1), .num(num1),
    .num_valid(nv1), .err(er1), .busy(bs1)
  );

  mors_to_num #(.UNIT_CYC(4)) dut4 (
    .clk(clk), .rst(rst), .mors(mors4), .num(num4),
    .num_valid(nv4), .err(er4), .busy(bs4)
  );

  assign mors1 = sel ? 1'b0 : m;
  assign mors4 = sel ? m : 1'b0;
  assign o_num = sel ? num4 : num1;
  assign o_nv  = sel ? nv4 : nv1;
  assign o_er  = sel ? er4 : er1;
  assign o_bs  = sel ? bs4 : bs1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic v);
    m = v;
    @(posedge clk);
    #1;
  endtask

  // Reference: -1 for a malformed number, otherwise its value
  function automatic int eval_word();
    int  acc = 0;
    bit  bad = 1'b0;
    for (int c = 0; c < word_q.size(); c++) begin
      int d = -1;
      for (int k = 0; k < 10; k++) if (word_q[c] == pat[k]) d = k;
      if (d < 0) bad = 1'b1;
      else if (!bad) begin
        acc = acc * 10 + d;
        if (acc > 31) bad = 1'b1;
      end
    end
    return bad ? -1 : acc;
  endfunction

  task automatic quiet(input string tag, input int k, input bit bsy);
    chk($sformatf("%s/nv", tag), o_nv, 0);
    chk($sformatf("%s/err", tag), o_er, 0);
    chk($sformatf("%s/busy", tag), o_bs, bsy);
    chk($sformatf("%s/num", tag), o_num, exp_num[k]);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) begin
      tick(1'b0);
      quiet(tag, sel ? 1 : 0, 1'b0);
    end
  endtask

  // mode 0: random lengths, 1: boundary lengths, 2: nominal lengths
  task automatic send_word(input int mode, input string tag);
    int    r, k, len;
    string s;
    r = eval_word();
    k = sel ? 1 : 0;
    for (int c = 0; c < word_q.size(); c++) begin
      s = word_q[c];
      for (int e = 0; e < s.len(); e++) begin
        if (s[e] == DASH_CH)
          len = (mode == 2) ? 3 * u : (mode == 1) ? 2 * u : int'($urandom_range(2 * u, 8 * u));
        else
          len = (mode == 2) ? u : (mode == 1) ? 2 * u - 1 : int'($urandom_range(u, 2 * u - 1));
        repeat (len) begin tick(1'b1); quiet(tag, k, 1'b1); end
        if (e < s.len() - 1) begin
          len = (mode == 2) ? u : (mode == 1) ? 3 * u - 1 : int'($urandom_range(1, 3 * u - 1));
          repeat (len) begin tick(1'b0); quiet(tag, k, 1'b1); end
        end
      end
      if (c < word_q.size() - 1) begin
        len = (mode == 2) ? 3 * u : (mode == 1) ? 7 * u - 1 : int'($urandom_range(3 * u, 7 * u - 1));
        repeat (len) begin tick(1'b0); quiet(tag, k, 1'b1); end
      end
    end
    repeat (7 * u - 1) begin tick(1'b0); quiet(tag, k, 1'b1); end
    tick(1'b0);
    if (r >= 0) exp_num[k] = r;
    chk($sformatf("%s/pulse_nv", tag), o_nv, (r >= 0) ? 1 : 0);
    chk($sformatf("%s/pulse_err", tag), o_er, (r < 0) ? 1 : 0);
    chk($sformatf("%s/pulse_num", tag), o_num, exp_num[k]);
    chk($sformatf("%s/pulse_busy", tag), o_bs, 0);
  endtask

  task automatic set_unit(input logic s);
    sel = s;
    u   = s ? 4 : 1;
  endtask

  initial begin
    pat = '{"-----", ".----", "..---", "...--", "....-",
            ".....", "-....", "--...", "---..", "----."};
    exp_num[0] = 0;
    exp_num[1] = 0;
    m   = 1'b0;
    set_unit(1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/num1", num1, 0);  chk("rst/nv1", nv1, 0);
    chk("rst/err1", er1, 0);   chk("rst/busy1", bs1, 0);
    chk("rst/num4", num4, 0);  chk("rst/nv4", nv4, 0);
    rst = 1'b1;
    idle(5, "idle0");

    word_q = '{".----"};           send_word(2, "t1_one");
    word_q = '{"..---", "...--"};  send_word(2, "t2_23");
    idle(3, "idle1");
    word_q = '{"...--", "..---"};  send_word(2, "t3_ovf");
    word_q = '{".-.-."};           send_word(2, "t4_bad");
    word_q = '{".---"};            send_word(2, "t4_short");
    word_q = '{"......"};          send_word(2, "t4_long");
    word_q = '{"-...."};           send_word(2, "t4_six");
    idle(20, "idle2");

    // Reset in the middle of a character
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid/num1", num1, 0); chk("rst_mid/nv1", nv1, 0);
    chk("rst_mid/err1", er1, 0);  chk("rst_mid/busy1", bs1, 0);
    exp_num[0] = 0;
    exp_num[1] = 0;
    m = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    word_q = '{"-----"};           send_word(2, "t5_zero");
    word_q = '{"..---"};           send_word(1, "t5_two_edge");

    set_unit(1'b1);
    idle(2, "idle4");
    word_q = '{"....."};           send_word(2, "t6_five");
    word_q = '{"-...."};           send_word(1, "t6_edge6");
    word_q = '{".----", "-----"};  send_word(1, "t6_edge10");

    for (int i = 0; i < 40; i++) begin
      int    nch;
      string s;
      set_unit(1'($urandom_range(0, 1)));
      word_q.delete();
      nch = (($urandom_range(0, 9)) < 5) ? 1 : int'($urandom_range(2, 3));
      for (int c = 0; c < nch; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          s = "";
          repeat ($urandom_range(1, 6)) s = $sformatf("%s%s", s, ($urandom_range(0, 1) == 1) ? "-" : ".");
          word_q.push_back(s);
        end else begin
          word_q.push_back(pat[$urandom_range(0, 9)]);
        end
      end
      send_word(0, $sformatf("rnd%0d", i));
      idle(int'($urandom_range(0, 3)), $sformatf("rnd%0d_idle", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
